uart_rx: RTL and testbench

- 8N1 UART receiver: the receiving end of the team's UART link.
- Oversamples the serial line, detects the start bit, samples 8 data bits LSB-first at mid-bit, then checks the stop bit.
- Presents the received byte with a one-cycle done strobe, or a framing-error strobe on a bad stop bit.
- Sits between the board RX pin and the byte consumer; exposes its state and shift register for debug.

---
 rtl/uart_rx_if.sv | 32 +++
 rtl/uart_rx.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if -- bus bundle between the board RX pin side and the uart_rx
// receiver.
//   master : the line driver / byte consumer (drives RX, reads results)
//   slave  : the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_if;
    logic       RX;           // serial line, idles high
    logic [7:0] data_out;     // last correctly framed byte
    logic       done;         // one-cycle pulse when data_out updates
    logic       framing_err;  // one-cycle pulse on a low stop bit
    logic [7:0] rx_shift;     // debug: live shift register
    logic [1:0] rxstate;      // debug: current receiver state

    modport master (
        output RX,
        input  data_out,
        input  done,
        input  framing_err,
        input  rx_shift,
        input  rxstate
    );

    modport slave (
        input  RX,
        output data_out,
        output done,
        output framing_err,
        output rx_shift,
        output rxstate
    );
endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver.
//
// The serial line is synchronised into rx_s, a 1->0 edge on rx_s starts a
// frame, the start bit is re-checked at mid-bit, then 8 data bits (LSB
// first) and the stop bit are sampled once per bit period at mid-bit.
// A good stop bit updates data_out with a one-cycle done strobe; a low stop
// bit produces a one-cycle framing_err strobe and leaves data_out alone.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN -- every mid-bit sample becomes the 2-of-3 majority
//                          of a 3-deep history of rx_s; sample timing is
//                          unchanged.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16   // rx_clk cycles per bit; even, >= 8
) (
    input  logic      rx_clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);

    localparam int              TICK_W   = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // Input conditioning
    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rx_s;
    logic sample;

    // Receiver state
    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_q,  tick_d;
    logic [2:0]        bit_q,   bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q,  data_d;
    logic              done_q,  done_d;
    logic              ferr_q,  ferr_d;

    assign rx_s = sync2_q;

    // Two-flop synchroniser on RX plus the previous-value flop used for
    // falling-edge detection; all reset high so an idle line never looks
    // like a start edge coming out of reset.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let each flop capture the value
            // its neighbour held before this edge, which is what makes the
            // chain a true two-stage synchroniser.
            sync1_q <= bus.RX;
            sync2_q <= sync1_q;
            prev_q  <= rx_s;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] hist_q;

    // Three most recent rx_s values for the majority vote.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 3'b111;
        end else begin
            hist_q <= {hist_q[1:0], rx_s};
        end
    end

    assign sample = (hist_q[0] & hist_q[1]) |
                    (hist_q[0] & hist_q[2]) |
                    (hist_q[1] & hist_q[2]);
`else
    assign sample = rx_s;
`endif

    // State and datapath registers.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state and datapath logic for the frame sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a genuine 1->0 transition arms a frame; a line that
                // is already low (break) never retriggers.
                if (prev_q && !rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end

            START: begin
                if (tick_q == TICK_MID) begin
                    if (sample) begin
                        // Glitch rather than a start bit.
                        state_d = IDLE;
                    end else begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            DATA: begin
                if (tick_q == TICK_END) begin
                    tick_d  = '0;
                    shift_d = {sample, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            STOP: begin
                if (tick_q == TICK_END) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    if (sample) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_out    = data_q;
    assign bus.done        = done_q;
    assign bus.framing_err = ferr_q;
    assign bus.rx_shift    = shift_q;
    assign bus.rxstate     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed bench for uart_rx (OVERSAMPLE = 16).
//
// Each frame is built as a 160-cycle waveform. A waveform-level model picks
// the value seen at each mid-bit point, predicts the byte/strobe and the
// cycle on which the strobe must appear (start edge + 155), and queues that
// event. A compare process checks done, framing_err and data_out against
// the queued events on every negative clock edge.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS        = 16;
    localparam int FRAME_LEN = 10 * OS;
    localparam int STROBE_AT = 155;   // 9.5 bit periods + 3 cycles

    typedef struct {
        int         cyc;
        bit         good;
        logic [7:0] data;
    } ev_t;

    logic rx_clk = 1'b0;
    logic rst_n  = 1'b0;

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .rx_clk (rx_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 rx_clk = ~rx_clk;

    int  cyc = 0;
    always @(posedge rx_clk) cyc <= cyc + 1;

    int  n_checks = 0;
    int  n_errors = 0;

    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    bit         cmp_en = 1'b0;
    bit         exp_done;
    bit         exp_fe;
    int         n_done_seen = 0;
    int         n_fe_seen   = 0;
    int         last_done_cyc = 0;
    int         prev_done_cyc = 0;
    bit         wave [0:FRAME_LEN-1];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Value the receiver must take for frame bit b (0 = start, 9 = stop).
    function automatic bit samp(input int b);
`ifdef UART_RX_MAJORITY_EN
        int c;
        int ones;
        c    = OS * b + OS / 2 - 3;
        ones = int'(wave[c]) + int'(wave[c + 1]) + int'(wave[c + 2]);
        return ones >= 2;
`else
        return wave[OS * b + OS / 2];
`endif
    endfunction

    // Per-cycle comparison against the event queue.
    always @(negedge rx_clk) begin
        if (cmp_en) begin
            exp_done = 1'b0;
            exp_fe   = 1'b0;
            if (!rst_n) begin
                model_data = 8'h00;
            end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                if (exp_q[0].good) begin
                    exp_done   = 1'b1;
                    model_data = exp_q[0].data;
                end else begin
                    exp_fe = 1'b1;
                end
                void'(exp_q.pop_front());
            end
            check("done", bus.done, exp_done);
            check("framing_err", bus.framing_err, exp_fe);
            check("data_out", bus.data_out, model_data);
            if (bus.done === 1'b1) begin
                n_done_seen++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
            end
            if (bus.framing_err === 1'b1) n_fe_seen++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge rx_clk);
            #1 bus.RX = 1'b1;
        end
    endtask

    // Drive ncyc cycles of an 8N1 frame; glitch >= 0 inverts that one cycle.
    task automatic send_frame(input logic [7:0] d, input bit stop,
                              input int glitch, input int ncyc);
        int   start;
        ev_t  ev;
        logic [7:0] byte_v;
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (k < OS)            wave[k] = 1'b0;
            else if (k < 9 * OS)   wave[k] = d[(k - OS) / OS];
            else                   wave[k] = stop;
            if (k == glitch)       wave[k] = ~wave[k];
        end
        @(posedge rx_clk);
        #1;
        start  = cyc;
        bus.RX = wave[0];
        if (ncyc == FRAME_LEN && !samp(0)) begin
            for (int b = 0; b < 8; b++) byte_v[b] = samp(b + 1);
            ev.cyc  = start + STROBE_AT;
            ev.good = samp(9);
            ev.data = byte_v;
            exp_q.push_back(ev);
        end
        for (int k = 1; k < ncyc; k++) begin
            @(posedge rx_clk);
            #1 bus.RX = wave[k];
        end
    endtask

    task automatic wait_cyc(input int target);
        do @(negedge rx_clk); while (cyc < target);
    endtask

    initial begin
        int s;
        int d0;
        bus.RX = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(posedge rx_clk);
        #2;
        check("reset data_out", bus.data_out, 8'h00);
        check("reset done", bus.done, 1'b0);
        check("reset framing_err", bus.framing_err, 1'b0);
        check("reset rx_shift", bus.rx_shift, 8'h00);
        check("reset rxstate", bus.rxstate, 2'd0);
        @(posedge rx_clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;
        idle(5);

        // Good frame 0xA5.
        d0 = n_done_seen;
        send_frame(8'hA5, 1'b1, -1, FRAME_LEN);
        idle(20);
        check("A5 data_out", bus.data_out, 8'hA5);
        check("A5 rx_shift", bus.rx_shift, 8'hA5);
        check("A5 rxstate", bus.rxstate, 2'd0);
        check("A5 done count", n_done_seen - d0, 1);
        check("A5 fe count", n_fe_seen, 0);

        // False start: 4 low cycles.
        d0 = n_done_seen;
        @(posedge rx_clk);
        #1;
        s = cyc;
        bus.RX = 1'b0;
        repeat (3) begin
            @(posedge rx_clk);
            #1 bus.RX = 1'b0;
        end
        @(posedge rx_clk);
        #1 bus.RX = 1'b1;
        wait_cyc(s + 5);
        check("false start in START", bus.rxstate, 2'd1);
        wait_cyc(s + 12);
        check("false start back IDLE", bus.rxstate, 2'd0);
        idle(10);
        check("false start data_out", bus.data_out, 8'hA5);
        check("false start done count", n_done_seen - d0, 0);
        check("false start fe count", n_fe_seen, 0);

        // 0x3C with a low stop bit, then a 3-bit-period break.
        send_frame(8'h3C, 1'b0, -1, FRAME_LEN);
        for (int i = 0; i < 3 * OS; i++) begin
            @(posedge rx_clk);
            #1 bus.RX = 1'b0;
        end
        check("break rxstate", bus.rxstate, 2'd0);
        check("break data_out", bus.data_out, 8'hA5);
        check("framing err count", n_fe_seen, 1);
        check("framing done count", n_done_seen - d0, 0);
        idle(30);
        check("after break rxstate", bus.rxstate, 2'd0);

        // Back-to-back 0x00 then 0xFF.
        d0 = n_done_seen;
        send_frame(8'h00, 1'b1, -1, FRAME_LEN);
        send_frame(8'hFF, 1'b1, -1, FRAME_LEN);
        idle(20);
        check("b2b done count", n_done_seen - d0, 2);
        check("b2b done spacing", last_done_cyc - prev_done_cyc, 160);
        check("b2b data_out", bus.data_out, 8'hFF);

        // Reset during data bit 4 of 0x5A.
        send_frame(8'h5A, 1'b1, -1, 85);
        #3;
        check("mid-frame rxstate", bus.rxstate, 2'd2);
        check("mid-frame rx_shift", bus.rx_shift, 8'hAF);
        rst_n = 1'b0;
        #1;
        check("async reset data_out", bus.data_out, 8'h00);
        check("async reset rx_shift", bus.rx_shift, 8'h00);
        check("async reset rxstate", bus.rxstate, 2'd0);
        check("async reset done", bus.done, 1'b0);
        @(posedge rx_clk);
        #1 bus.RX = 1'b1;
        repeat (2) @(posedge rx_clk);
        #1 rst_n = 1'b1;
        idle(10);

        // 0x81 after reset.
        d0 = n_done_seen;
        send_frame(8'h81, 1'b1, -1, FRAME_LEN);
        idle(20);
        check("81 data_out", bus.data_out, 8'h81);
        check("81 done count", n_done_seen - d0, 1);

        // 0xF0 with a one-cycle glitch at the centre of data bit 3.
        send_frame(8'hF0, 1'b1, 4 * OS + OS / 2, FRAME_LEN);
        idle(20);
`ifdef UART_RX_MAJORITY_EN
        check("glitch data_out", bus.data_out, 8'hF0);
`else
        check("glitch data_out", bus.data_out, 8'hF8);
`endif

        check("pending events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
